// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - sequenced per-stage reset release with ack handshake and timeout
// Synchronized power-on release, hold, then stage-by-stage release gated by level acks.
module rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 8,
  parameter int STAGE_GAP   = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  soft_rst,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [2:0]            err_stage
);

  localparam int HOLD_LAST = HOLD_CYC - 1;
  localparam int GAP_LAST  = STAGE_GAP - 1;
  localparam int TO_LAST   = ACK_TIMEOUT - 1;
  localparam int HG_MAX    = (HOLD_LAST > GAP_LAST) ? HOLD_LAST : GAP_LAST;
  localparam int CNT_MAX   = (HG_MAX > TO_LAST) ? HG_MAX : TO_LAST;
  localparam int CW        = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int IW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [2:0] {RST, HOLD, WAIT_ACK, GAP, DONE, ERR} state_t;

  state_t                  state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [NUM_STAGES-1:0]   stage_rst_nx;
  logic                    busy_nx, done_nx, terr_nx;
  logic [2:0]              err_stage_nx;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rst_sync;

  // Asynchronous assert, synchronous deassert of the internal release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST;
      idx         <= '0;
      cnt         <= '0;
      stage_rst   <= '1;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= 3'd0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      stage_rst   <= stage_rst_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      timeout_err <= terr_nx;
      err_stage   <= err_stage_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    stage_rst_nx = stage_rst;
    busy_nx      = busy;
    done_nx      = done;
    terr_nx      = timeout_err;
    err_stage_nx = err_stage;
    if (!rst_sync || soft_rst) begin
      // A soft request only counts once the power-on synchronizer has released.
      state_nx     = rst_sync ? HOLD : RST;
      idx_nx       = '0;
      cnt_nx       = '0;
      stage_rst_nx = '1;
      busy_nx      = 1'b1;
      done_nx      = 1'b0;
      terr_nx      = 1'b0;
      err_stage_nx = 3'd0;
    end else begin
      case (state)
        RST: begin
          // The first synchronized edge already counts as one hold cycle.
          if (HOLD_LAST == 0) begin
            state_nx        = WAIT_ACK;
            stage_rst_nx[0] = 1'b0;
          end else begin
            state_nx = HOLD;
            cnt_nx   = CW'(1);
          end
        end
        HOLD: begin
          if (cnt == CW'(HOLD_LAST)) begin
            state_nx        = WAIT_ACK;
            cnt_nx          = '0;
            idx_nx          = '0;
            stage_rst_nx[0] = 1'b0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        WAIT_ACK: begin
          if (stage_ack[idx]) begin
            cnt_nx = '0;
            if (idx == IW'(NUM_STAGES - 1)) begin
              state_nx = DONE;
              busy_nx  = 1'b0;
              done_nx  = 1'b1;
            end else begin
              state_nx = GAP;
            end
          end else if (cnt == CW'(TO_LAST)) begin
            state_nx     = ERR;
            busy_nx      = 1'b0;
            terr_nx      = 1'b1;
            err_stage_nx = 3'(idx);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_LAST)) begin
            state_nx             = WAIT_ACK;
            cnt_nx               = '0;
            idx_nx               = idx + IW'(1);
            stage_rst_nx[idx_nx] = 1'b0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        DONE, ERR: ;
        default: state_nx = RST;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - table/scoreboard bench for rst_seq with default parameters
// Edge numbering: E0 is the first rising edge after rst_n rises; samples taken on the falling edge.
module tb_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       soft_rst;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [2:0] err_stage;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    int         scen;
    int         e;
    logic [2:0] srst;
    logic       busy;
    logic       done;
    logic       terr;
    logic [2:0] es;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  rst_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_rst   (soft_rst),
    .stage_ack  (stage_ack),
    .stage_rst  (stage_rst),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .err_stage  (err_stage)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] outs();
    return {stage_rst, busy, done, timeout_err, err_stage};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {rst,busy,done,terr,es}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic add(input int scen, input int e, input logic [2:0] srst,
                     input logic b, input logic d, input logic t, input logic [2:0] es);
    vec_t v;
    v.scen = scen; v.e = e; v.srst = srst; v.busy = b; v.done = d; v.terr = t; v.es = es;
    tbl.push_back(v);
  endtask

  task automatic load(input int scen);
    foreach (tbl[k]) if (tbl[k].scen == scen) sb.push_back(tbl[k]);
  endtask

  task automatic drive(input int scen, input int n);
    soft_rst = 1'b0;
    case (scen)
      1: if (n == 11) stage_ack[0] = 1'b0;
      2: soft_rst = (n == 39);
      4: soft_rst = (n == 19) || (n >= 39 && n <= 41);
      7: soft_rst = (n == 15);
      default: ;
    endcase
  endtask

  task automatic run(input int scen, input int last);
    int   n;
    vec_t v;
    do begin
      @(negedge clk);
      n = cyc - base - 1;
      while (sb.size() > 0 && sb[0].e <= n) begin
        v = sb.pop_front();
        check($sformatf("s%0d_E%0d", v.scen, v.e), outs(),
              {v.srst, v.busy, v.done, v.terr, v.es});
      end
      drive(scen, n);
    end while (n < last);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      errors++;
      checks++;
      $display("FAIL s%0d_E%0d: never reached within bound, expected %b", v.scen, v.e,
               {v.srst, v.busy, v.done, v.terr, v.es});
    end
  endtask

  task automatic do_reset(input logic [2:0] ack);
    @(negedge clk);
    rst_n = 1'b0;
    soft_rst = 1'b0;
    stage_ack = ack;
    #1 check("rst_async", outs(), 9'b111_1_0_0_000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
  endtask

  initial begin
    rst_n = 1'b0;
    soft_rst = 1'b0;
    stage_ack = 3'b000;

    // acks tied high, ack0 dropped after acceptance
    add(1, 0, 3'b111, 1, 0, 0, 0);  add(1, 8, 3'b111, 1, 0, 0, 0);
    add(1, 9, 3'b110, 1, 0, 0, 0);  add(1, 11, 3'b110, 1, 0, 0, 0);
    add(1, 12, 3'b100, 1, 0, 0, 0); add(1, 14, 3'b100, 1, 0, 0, 0);
    add(1, 15, 3'b000, 1, 0, 0, 0); add(1, 16, 3'b000, 0, 1, 0, 0);
    add(1, 24, 3'b000, 0, 1, 0, 0);
    // stage 1 never acks, then soft_rst out of ERR
    add(2, 12, 3'b100, 1, 0, 0, 0); add(2, 27, 3'b100, 1, 0, 0, 0);
    add(2, 28, 3'b100, 0, 0, 1, 1); add(2, 36, 3'b100, 0, 0, 1, 1);
    add(2, 40, 3'b111, 1, 0, 0, 0); add(2, 47, 3'b111, 1, 0, 0, 0);
    add(2, 48, 3'b110, 1, 0, 0, 0);
    // only ack2 high: ignored while stage 0 pending
    add(3, 9, 3'b110, 1, 0, 0, 0);  add(3, 12, 3'b110, 1, 0, 0, 0);
    add(3, 24, 3'b110, 1, 0, 0, 0); add(3, 25, 3'b110, 0, 0, 1, 0);
    add(3, 30, 3'b110, 0, 0, 1, 0);
    // soft_rst pulse in DONE, then held for three edges
    add(4, 16, 3'b000, 0, 1, 0, 0); add(4, 20, 3'b111, 1, 0, 0, 0);
    add(4, 27, 3'b111, 1, 0, 0, 0); add(4, 28, 3'b110, 1, 0, 0, 0);
    add(4, 31, 3'b100, 1, 0, 0, 0); add(4, 34, 3'b000, 1, 0, 0, 0);
    add(4, 35, 3'b000, 0, 1, 0, 0); add(4, 40, 3'b111, 1, 0, 0, 0);
    add(4, 42, 3'b111, 1, 0, 0, 0); add(4, 49, 3'b111, 1, 0, 0, 0);
    add(4, 50, 3'b110, 1, 0, 0, 0);
    // into GAP, then resequence after async rst_n pulse
    add(5, 10, 3'b110, 1, 0, 0, 0);
    add(6, 0, 3'b111, 1, 0, 0, 0);  add(6, 8, 3'b111, 1, 0, 0, 0);
    add(6, 9, 3'b110, 1, 0, 0, 0);  add(6, 16, 3'b000, 0, 1, 0, 0);
    // soft_rst coincides with last-stage ack
    add(7, 15, 3'b000, 1, 0, 0, 0); add(7, 16, 3'b111, 1, 0, 0, 0);
    add(7, 17, 3'b111, 1, 0, 0, 0); add(7, 24, 3'b110, 1, 0, 0, 0);

    do_reset(3'b111); load(1); run(1, 24);
    do_reset(3'b101); load(2); run(2, 48);
    do_reset(3'b100); load(3); run(3, 30);
    do_reset(3'b111); load(4); run(4, 52);

    do_reset(3'b111); load(5); run(5, 10);
    #1 rst_n = 1'b0;
    #2 check("rst_mid_gap", outs(), 9'b111_1_0_0_000);
    #1 rst_n = 1'b1;
    base = cyc;
    load(6); run(6, 20);

    do_reset(3'b111); load(7); run(7, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
